rails_feeder: RTL and testbench

//  Upstream stage of the rails permutation checker. Buffers host-written nibbles in a FIFO.

---
 rtl/rails_feeder.sv | 163 ++++++++++++++++
 tb/tb_rails_feeder.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rails_feeder.sv
// rails_feeder: buffers host nibbles and streams one complete rails pattern
// (header N, then N coaches) to the checker, one verdict at a time.
module rails_feeder #(
  parameter int MAX_N      = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] data,
  input  logic       chk_valid,
  input  logic       chk_result,
  output logic       busy,
  output logic       pat_done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic       err_hdr,
  output logic       err_tmo
);

  // state | meaning
  // IDLE  | wait for a complete pattern in the FIFO; discard illegal headers
  // SEND  | pop header and N coaches onto data, one per cycle
  // WAIT  | wait for the checker verdict or the timeout
  // GAP   | hold data at 0 before the next header

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_N + 2);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [3:0] MAX_N4 = 4'(MAX_N);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  logic [SW-1:0]  send_left;
  logic [WW-1:0]  wait_cnt, wait_inc;
  logic [GW-1:0]  gap_cnt;

  logic [3:0]     head;
  logic [CW-1:0]  need;
  logic           hdr_bad, wr_en;
  logic           pop, drop_hdr, send_load, verdict, tmo_hit, gap_load;

  assign head     = mem[rd_ptr];
  assign hdr_bad  = (head == 4'd0) || (head > MAX_N4);
  assign need     = CW'(head) + CW'(1);
  assign in_ready = (fifo_cnt != CW'(FIFO_DEPTH));
  assign wr_en    = in_valid & in_ready;
  assign busy     = (state != IDLE);
  assign wait_inc = wait_cnt + WW'(1);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    drop_hdr  = 1'b0;
    send_load = 1'b0;
    verdict   = 1'b0;
    tmo_hit   = 1'b0;
    gap_load  = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_cnt != '0) begin
          if (hdr_bad) begin
            pop      = 1'b1;
            drop_hdr = 1'b1;
          end else if (fifo_cnt >= need) begin
            state_nxt = SEND;
            send_load = 1'b1;
          end
        end
      end
      SEND: begin
        pop = 1'b1;
        if (send_left == SW'(1)) state_nxt = WAIT;
      end
      WAIT: begin
        if (chk_valid) begin
          verdict   = 1'b1;
          gap_load  = 1'b1;
          state_nxt = GAP;
        end else if (wait_inc == WW'(TIMEOUT)) begin
          tmo_hit   = 1'b1;
          gap_load  = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt <= GW'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      send_left <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      data      <= 4'd0;
    end else begin
      if (send_load)
        send_left <= SW'(head) + SW'(1);
      else if (state == SEND)
        send_left <= send_left - SW'(1);
      wait_cnt <= (state == WAIT) ? wait_inc : '0;
      if (gap_load)
        gap_cnt <= GW'(GAP_CYCLES);
      else if ((state == GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - GW'(1);
      data <= (state == SEND) ? head : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pass_cnt <= 8'd0;
      fail_cnt <= 8'd0;
      err_hdr  <= 1'b0;
      err_tmo  <= 1'b0;
      pat_done <= 1'b0;
    end else begin
      if (verdict && chk_result && (pass_cnt != 8'hFF))
        pass_cnt <= pass_cnt + 8'd1;
      if (((verdict && !chk_result) || tmo_hit) && (fail_cnt != 8'hFF))
        fail_cnt <= fail_cnt + 8'd1;
      err_hdr  <= err_hdr | drop_hdr;
      err_tmo  <= err_tmo | tmo_hit;
      pat_done <= verdict | tmo_hit;
    end
  end

endmodule

// File: tb/tb_rails_feeder.sv
// Scoreboard bench for rails_feeder: a host-stream parser predicts patterns,
// a negedge monitor plays the checker and compares stream, verdicts and stats.
`timescale 1ns/1ps
module tb_rails_feeder;
  localparam int MAX_N = 10;
  localparam int GAP   = 2;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] data;
  logic       chk_valid = 1'b0;
  logic       chk_result = 1'b0;
  logic       busy, pat_done, err_hdr, err_tmo;
  logic [7:0] pass_cnt, fail_cnt;

  rails_feeder #(.MAX_N(MAX_N), .FIFO_DEPTH(16), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .chk_valid(chk_valid), .chk_result(chk_result), .busy(busy),
    .pat_done(pat_done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_hdr(err_hdr), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [3:0] v [11];
    bit         tmo;
    bit         res;
    int         dly;
    bit         bad_before;
  } pat_t;

  pat_t exp_q[$];
  int   vecs = 0;
  int   miss = 0;

  // host-side model state
  bit         p_active = 0;
  pat_t       p_cur;
  int         p_got = 0;
  bit         exp_err_hdr = 0;
  bit         nxt_tmo = 0, nxt_res = 0;
  int         nxt_dly = 0;
  logic [3:0] coach [10];

  // monitor / checker state
  bit   in_stream = 0, pend = 0, have_done = 0;
  pat_t cur, waiting;
  int   idx = 0, wait_cycles = 0, since_done = 0;
  int   exp_pass = 0, exp_fail = 0;
  bit   exp_tmo = 0;

  task automatic check(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Parse the accepted host nibble stream into expected patterns.
  function automatic void model_accept(input logic [3:0] v);
    if (!p_active) begin
      if (v == 4'd0 || int'(v) > MAX_N) exp_err_hdr = 1;
      else begin
        p_cur.n = int'(v);
        p_cur.v[0] = v;
        p_cur.tmo = nxt_tmo;
        p_cur.res = nxt_res;
        p_cur.dly = nxt_dly;
        p_cur.bad_before = exp_err_hdr;
        p_got = 0;
        p_active = 1;
      end
    end else begin
      p_got++;
      p_cur.v[p_got] = v;
      if (p_got == p_cur.n) begin
        exp_q.push_back(p_cur);
        p_active = 0;
      end
    end
  endfunction

  task automatic put(input logic [3:0] v);
    bit ok = 0;
    int g = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!ok && g < 2000) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      g++;
    end
    in_valid = 1'b0;
    if (ok) model_accept(v);
    else check("put_timeout", g, 0);
  endtask

  task automatic write_pat(input int n, input bit tmo, input bit res, input int dly);
    nxt_tmo = tmo; nxt_res = res; nxt_dly = dly;
    put(4'(n));
    for (int i = 0; i < n; i++) put(coach[i]);
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while ((exp_q.size() != 0 || p_active || in_stream || pend || busy) && g < limit) begin
      @(negedge clk);
      g++;
    end
    if (g >= limit) check("drain_timeout", g, 0);
    repeat (4) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      in_stream = 0; pend = 0; have_done = 0; idx = 0;
      wait_cycles = 0; since_done = 0;
      exp_pass = 0; exp_fail = 0; exp_tmo = 0;
      chk_valid = 1'b0; chk_result = 1'b0;
      exp_q.delete();
    end else begin
      chk_valid = 1'b0;
      if (in_stream) begin
        if (idx <= cur.n) check($sformatf("coach_%0d", idx), int'(data), int'(cur.v[idx]));
        else begin
          check("tail_zero", int'(data), 0);
          in_stream = 0;
        end
        if (idx == cur.n) begin
          pend = 1; wait_cycles = 0; waiting = cur;
        end
        idx++;
      end else if (data != 4'd0) begin
        if (exp_q.size() == 0) check("unexpected_header", int'(data), 0);
        else begin
          cur = exp_q.pop_front();
          check("header", int'(data), int'(cur.v[0]));
          if (have_done) check("gap_zeros", (since_done >= GAP) ? 1 : 0, 1);
          in_stream = 1; idx = 1;
        end
      end

      if (pat_done) begin
        if (!pend) check("stray_pat_done", int'(pat_done), 0);
        else begin
          if (waiting.tmo) begin
            exp_fail = sat(exp_fail + 1);
            exp_tmo  = 1;
            check("tmo_latency", (wait_cycles >= TMO && wait_cycles <= TMO + 1) ? 1 : 0, 1);
          end else begin
            if (waiting.res) exp_pass = sat(exp_pass + 1);
            else             exp_fail = sat(exp_fail + 1);
            check("verdict_latency", wait_cycles, waiting.dly + 1);
          end
          check("pass_cnt", int'(pass_cnt), exp_pass);
          check("fail_cnt", int'(fail_cnt), exp_fail);
          check("err_tmo", int'(err_tmo), int'(exp_tmo));
          check("err_hdr", int'(err_hdr), int'(waiting.bad_before));
          pend = 0; have_done = 1; since_done = 0;
        end
      end else if (pend) begin
        if (wait_cycles > TMO + 4) begin
          check("verdict_missing", int'(pat_done), 1);
          pend = 0;
        end else if (!waiting.tmo && wait_cycles == waiting.dly) begin
          chk_valid  = 1'b1;
          chk_result = waiting.res;
        end
        wait_cycles++;
      end else if (!in_stream) begin
        if (data == 4'd0) since_done++;
        // verdict strobes while no pattern is outstanding must be ignored
        if ($urandom_range(7, 0) == 0) begin
          chk_valid  = 1'b1;
          chk_result = 1'($urandom_range(1, 0));
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, bad;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pat_done", int'(pat_done), 0);
    check("rst_pass", int'(pass_cnt), 0);
    check("rst_fail", int'(fail_cnt), 0);
    check("rst_err_hdr", int'(err_hdr), 0);
    check("rst_err_tmo", int'(err_tmo), 0);
    reset = 1'b1;
    @(negedge clk);

    // basic pass
    coach[0] = 4'd1; coach[1] = 4'd2; coach[2] = 4'd3; coach[3] = 4'd4; coach[4] = 4'd5;
    write_pat(5, 0, 1, 2);
    wait_idle(500);
    check("t1_pass_cnt", int'(pass_cnt), 1);

    // fail then pass, gap enforced by the monitor
    coach[0] = 4'd5; coach[1] = 4'd4; coach[2] = 4'd1; coach[3] = 4'd2; coach[4] = 4'd3;
    write_pat(5, 0, 0, 1);
    coach[0] = 4'd3; coach[1] = 4'd2; coach[2] = 4'd1;
    write_pat(3, 0, 1, 0);
    wait_idle(500);
    check("t2_fail_cnt", int'(fail_cnt), 1);
    check("t2_pass_cnt", int'(pass_cnt), 2);

    // illegal headers dropped
    put(4'd0);
    put(4'd11);
    coach[0] = 4'd2; coach[1] = 4'd1;
    write_pat(2, 0, 1, 3);
    wait_idle(500);
    check("t3_err_hdr", int'(err_hdr), 1);

    // partial pattern must not start
    nxt_tmo = 0; nxt_res = 1; nxt_dly = 4;
    put(4'd4); put(4'd1); put(4'd2);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (data != 4'd0 || busy) bad++;
    end
    check("partial_hold", bad, 0);
    put(4'd3); put(4'd4);
    wait_idle(500);
    check("t4_pass_cnt", int'(pass_cnt), 4);

    // timeout
    coach[0] = 4'd1; coach[1] = 4'd3; coach[2] = 4'd2;
    write_pat(3, 1, 0, 0);
    wait_idle(500);
    check("t5_err_tmo", int'(err_tmo), 1);
    check("t5_fail_cnt", int'(fail_cnt), 2);
    check("t5_busy", int'(busy), 0);

    // fill FIFO while waiting, drop an extra write, then reset mid-SEND
    coach[0] = 4'd7; coach[1] = 4'd6;
    write_pat(2, 1, 0, 0);
    g = 0;
    while (!pend && g < 100) begin @(negedge clk); g++; end
    check("t6_reach_wait", int'(pend), 1);
    for (int i = 0; i < 10; i++) coach[i] = 4'($urandom_range(15, 0));
    write_pat(10, 0, 1, 1);
    for (int i = 0; i < 4; i++) coach[i] = 4'($urandom_range(15, 0));
    write_pat(4, 0, 0, 1);
    check("full_in_ready", int'(in_ready), 0);
    in_data = 4'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!(in_stream && idx >= 4) && g < 300) begin @(negedge clk); g++; end
    check("t6_streaming", (in_stream && idx >= 4) ? 1 : 0, 1);
    reset = 1'b0;
    p_active = 0; exp_err_hdr = 0;
    repeat (2) @(negedge clk);
    check("mid_rst_pass", int'(pass_cnt), 0);
    check("mid_rst_fail", int'(fail_cnt), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err_tmo", int'(err_tmo), 0);
    reset = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (data != 4'd0 || busy || !in_ready) bad++;
    end
    check("post_rst_empty", bad, 0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(5, 0) == 0) begin
        int r;
        r = int'($urandom_range(5, 0));
        put((r == 0) ? 4'd0 : 4'(10 + r));
      end else begin
        int n;
        n = int'($urandom_range(MAX_N, 1));
        for (int i = 0; i < n; i++) coach[i] = 4'($urandom_range(15, 0));
        write_pat(n, ($urandom_range(9, 0) == 0), 1'($urandom_range(1, 0)),
                  int'($urandom_range(8, 0)));
      end
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
    wait_idle(4000);
    check("final_err_hdr", int'(err_hdr), int'(exp_err_hdr));
    check("final_pass", int'(pass_cnt), exp_pass);
    check("final_fail", int'(fail_cnt), exp_fail);
    check("final_err_tmo", int'(err_tmo), int'(exp_tmo));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
